data_block_memory: RTL and testbench

Block-granular backing data memory directly downstream of the data cache; it services the cache's 128-bit block refills and dirty-block write-backs. The cache drives READ/WRITE, BLOCK_ADDR and a 128-bit write block. This block answers with a fixed multi-cycle latency, holding BUSYWAIT high for the whole access. Each access moves one whole block of four 32-bit words.

---
 rtl/data_block_memory_if.sv | 19 +
 rtl/data_block_memory.sv | 87 ++++++++
 tb/tb_data_block_memory.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/data_block_memory_if.sv
// Cache-side block bus: request/address/data from the cache, data/stall back to it.
interface data_block_memory_if;
   logic         READ;
   logic         WRITE;
   logic [27:0]  BLOCK_ADDR;
   logic [127:0] WRITE_DATA;
   logic [127:0] READ_DATA;
   logic         BUSYWAIT;

   modport master (
      output READ, WRITE, BLOCK_ADDR, WRITE_DATA,
      input  READ_DATA, BUSYWAIT
   );

   modport slave (
      input  READ, WRITE, BLOCK_ADDR, WRITE_DATA,
      output READ_DATA, BUSYWAIT
   );
endinterface

// File: rtl/data_block_memory.sv
// Block-granular backing memory behind the data cache; fixed-latency 128-bit
// refills and write-backs with BUSYWAIT held for the whole access.
//
// state | meaning
// IDLE  | waiting; BUSYWAIT follows READ|WRITE combinationally
// BUSY  | access in flight, counter runs down to 0, access done on that edge
// DONE  | one-cycle completion, BUSYWAIT low, READ_DATA valid
module data_block_memory #(
   parameter int LATENCY    = 4,
   parameter int DEPTH_LOG2 = 8
) (
   input  logic                 CLK,
   input  logic                 RESET,
   data_block_memory_if.slave   bus
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                  state, state_nxt;
   logic [3:0]              cnt;
   logic                    op_wr;
   logic [DEPTH_LOG2-1:0]   idx;
   logic [127:0]            wdata;
   logic [127:0]            read_data;
   logic                    busy;
   logic [127:0]            mem [DEPTH];
   logic                    unused_addr;

   // addresses alias modulo the array size
   assign unused_addr = ^bus.BLOCK_ADDR[27:DEPTH_LOG2];

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            busy = bus.READ | bus.WRITE;
            if (bus.READ | bus.WRITE) state_nxt = BUSY;
         end
         BUSY: begin
            busy = 1'b1;
            if (cnt == 4'd0) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (RESET) busy = 1'b0;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         read_data <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (bus.READ | bus.WRITE) begin
                  // WRITE wins over a simultaneous READ
                  op_wr <= bus.WRITE;
                  idx   <= bus.BLOCK_ADDR[DEPTH_LOG2-1:0];
                  cnt   <= 4'(LATENCY - 1);
                  if (bus.WRITE) wdata <= bus.WRITE_DATA;
               end
            end
            BUSY: begin
               if (cnt != 4'd0) cnt <= cnt - 4'd1;
               else if (!op_wr) read_data <= mem[idx];
            end
            default: ;
         endcase
      end
   end

   // storage is not cleared by reset; an aborted write never commits
   always_ff @(posedge CLK) begin
      if (!RESET && state == BUSY && cnt == 4'd0 && op_wr)
         mem[idx] <= wdata;
   end

   assign bus.READ_DATA = read_data;
   assign bus.BUSYWAIT  = busy;

endmodule

// File: tb/tb_data_block_memory.sv
// Directed bench for data_block_memory (LATENCY=4, DEPTH_LOG2=8).
module tb_data_block_memory;

   logic CLK = 1'b0;
   logic RESET;
   int   n_checks = 0;
   int   n_fail   = 0;

   localparam logic [127:0] PAT_D = 128'hDEAD_BEEF_CAFE_BABE_0123_4567_0000_0001;

   data_block_memory_if bus ();

   data_block_memory #(.LATENCY(4), .DEPTH_LOG2(8)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   // Drive a request in an IDLE cycle and count negedges with BUSYWAIT high;
   // returns at the negedge of the first low cycle with the request still held.
   task automatic access(input logic w, input logic r, input logic [27:0] a,
                         input logic [127:0] d, output int hi);
      @(negedge CLK);
      bus.WRITE = w; bus.READ = r; bus.BLOCK_ADDR = a; bus.WRITE_DATA = d;
      #1;
      hi = 0;
      while (bus.BUSYWAIT === 1'b1 && hi < 40) begin
         hi++;
         @(negedge CLK);
      end
   endtask

   task automatic release_req();
      @(negedge CLK);
      bus.WRITE = 1'b0; bus.READ = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         n_checks++;
         if (bus.BUSYWAIT !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", bus.BUSYWAIT);
         end
         n_checks++;
         if (bus.READ_DATA !== 128'h0) begin
            n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.READ_DATA);
         end
      end
      RESET = 1'b0; bus.READ = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         n_checks++;
         if (bus.BUSYWAIT !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_after: got %b want 0", bus.BUSYWAIT);
         end
      end
   endtask

   task automatic test_write_read();
      int hi;
      access(1'b1, 1'b0, 28'h5, PAT_D, hi);
      n_checks++;
      if (hi !== 5) begin n_fail++; $display("FAIL wr_busy_len: got %0d want 5", hi); end
      n_checks++;
      if (bus.READ_DATA !== 128'h0) begin
         n_fail++; $display("FAIL wr_keeps_rdata: got %h want 0", bus.READ_DATA);
      end
      release_req();
      n_checks++;
      if (bus.BUSYWAIT !== 1'b0) begin
         n_fail++; $display("FAIL done_one_cycle: got %b want 0", bus.BUSYWAIT);
      end
      access(1'b0, 1'b1, 28'h5, 128'h0, hi);
      n_checks++;
      if (hi !== 5) begin n_fail++; $display("FAIL rd_busy_len: got %0d want 5", hi); end
      n_checks++;
      if (bus.READ_DATA !== PAT_D) begin
         n_fail++; $display("FAIL raw_data: got %h want %h", bus.READ_DATA, PAT_D);
      end
      release_req();
   endtask

   task automatic test_alias();
      int hi;
      access(1'b1, 1'b0, 28'h105, 128'hA5, hi);
      release_req();
      access(1'b0, 1'b1, 28'h005, 128'h0, hi);
      n_checks++;
      if (bus.READ_DATA !== 128'hA5) begin
         n_fail++; $display("FAIL alias: got %h want a5", bus.READ_DATA);
      end
      release_req();
   endtask

   task automatic test_back_to_back();
      int hi1, hi2, hi3;
      access(1'b1, 1'b0, 28'h13, 128'h1313, hi1);
      release_req();
      access(1'b1, 1'b0, 28'h3, 128'h3333_0000_3333, hi1);
      n_checks++;
      if (bus.BUSYWAIT !== 1'b0) begin
         n_fail++; $display("FAIL b2b_gap: got %b want 0", bus.BUSYWAIT);
      end
      access(1'b0, 1'b1, 28'h13, 128'h0, hi2);
      n_checks++;
      if (hi1 !== 5 || hi2 !== 5) begin
         n_fail++; $display("FAIL b2b_windows: got %0d/%0d want 5/5", hi1, hi2);
      end
      n_checks++;
      if (bus.READ_DATA !== 128'h1313) begin
         n_fail++; $display("FAIL b2b_refill: got %h want 1313", bus.READ_DATA);
      end
      release_req();
      access(1'b0, 1'b1, 28'h3, 128'h0, hi3);
      n_checks++;
      if (bus.READ_DATA !== 128'h3333_0000_3333) begin
         n_fail++; $display("FAIL b2b_writeback: got %h want 333300003333", bus.READ_DATA);
      end
      release_req();
   endtask

   task automatic test_reset_mid_write();
      int hi;
      access(1'b1, 1'b0, 28'h7, 128'h0, hi);
      release_req();
      access(1'b0, 1'b1, 28'h13, 128'h0, hi);
      release_req();
      @(negedge CLK);
      bus.WRITE = 1'b1; bus.BLOCK_ADDR = 28'h7; bus.WRITE_DATA = 128'hFF;
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b1; bus.WRITE = 1'b0;
      #1;
      n_checks++;
      if (bus.BUSYWAIT !== 1'b0) begin
         n_fail++; $display("FAIL midrst_busy: got %b want 0", bus.BUSYWAIT);
      end
      @(negedge CLK);
      n_checks++;
      if (bus.READ_DATA !== 128'h0) begin
         n_fail++; $display("FAIL midrst_rdata: got %h want 0", bus.READ_DATA);
      end
      RESET = 1'b0;
      @(negedge CLK);
      n_checks++;
      if (bus.BUSYWAIT !== 1'b0) begin
         n_fail++; $display("FAIL midrst_idle: got %b want 0", bus.BUSYWAIT);
      end
      access(1'b0, 1'b1, 28'h13, 128'h0, hi);
      release_req();
      access(1'b0, 1'b1, 28'h7, 128'h0, hi);
      n_checks++;
      if (bus.READ_DATA !== 128'h0) begin
         n_fail++; $display("FAIL midrst_not_committed: got %h want 0", bus.READ_DATA);
      end
      release_req();
   endtask

   task automatic test_simultaneous();
      int hi;
      access(1'b0, 1'b1, 28'h13, 128'h0, hi);
      release_req();
      access(1'b1, 1'b1, 28'h9, 128'h1234, hi);
      n_checks++;
      if (hi !== 5) begin n_fail++; $display("FAIL simul_busy_len: got %0d want 5", hi); end
      n_checks++;
      if (bus.READ_DATA !== 128'h1313) begin
         n_fail++; $display("FAIL simul_rdata_kept: got %h want 1313", bus.READ_DATA);
      end
      release_req();
      access(1'b0, 1'b1, 28'h9, 128'h0, hi);
      n_checks++;
      if (bus.READ_DATA !== 128'h1234) begin
         n_fail++; $display("FAIL simul_written: got %h want 1234", bus.READ_DATA);
      end
      release_req();
   endtask

   initial begin
      RESET = 1'b1;
      bus.READ = 1'b1; bus.WRITE = 1'b0;
      bus.BLOCK_ADDR = 28'h0; bus.WRITE_DATA = 128'h0;
      test_reset();
      test_write_read();
      test_alias();
      test_back_to_back();
      test_reset_mid_write();
      test_simultaneous();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
